// File: rtl/dma_pkg.sv
// Shared types and default widths for the DMA transfer controller slice.
package dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } dma_state_e;

  localparam int unsigned DefAddrWidth = 16;
  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefLenWidth  = 16;
  localparam int unsigned DefFifoDepth = 8;

endpackage

// File: rtl/dma_credit_cnt.sv
// Read-credit tracker: counts reads in flight plus FIFO occupancy and grants credit
// only while both together leave room in the FIFO.
module dma_credit_cnt import dma_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_acc,
  input  logic rd_rvalid,
  input  logic fifo_pop,
  output logic fifo_push,
  output logic credit_ok
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW:0] Limit = (CntW + 1)'(FIFO_DEPTH - 1);

  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [CntW:0]   used;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outst_q <= '0;
      occ_q   <= '0;
    end else begin
      outst_q <= outst_d;
      occ_q   <= occ_d;
    end
  end

  always_comb begin
    // Stray beats with nothing outstanding are dropped here, not pushed.
    fifo_push = rd_rvalid && (outst_q != '0);

    outst_d = outst_q;
    case ({rd_acc, fifo_push})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    occ_d = occ_q;
    case ({fifo_push, fifo_pop})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase

    used      = {1'b0, outst_q} + {1'b0, occ_q};
    credit_ok = used < Limit;
  end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Memory-to-memory DMA controller: reads into an external sync FIFO under credit
// control and drains it through a one-entry write holding register.
module dma_xfer_ctrl import dma_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned LEN_WIDTH  = DefLenWidth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  xfer_len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_rvalid,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  fifo_w_en,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_full,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_empty,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_gnt
);

  dma_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q;
  logic [LEN_WIDTH-1:0]  rd_rem_q, wr_rem_q;
  logic                  hold_valid_q, pop_inflight_q;
  logic [DATA_WIDTH-1:0] hold_data_q;

  logic start_acc, rd_acc, wr_acc, credit_ok;

  assign start_acc = start && (state_q == StIdle);
  assign rd_acc    = rd_req && rd_gnt;
  assign wr_acc    = hold_valid_q && wr_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = (xfer_len == '0) ? StDone : StRun;
      StRun:   if (rd_rem_q == '0) state_d = StFlush;
      StFlush: if (wr_acc && (wr_rem_q == LEN_WIDTH'(1))) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = state_q inside {StRun, StFlush};
    done    = state_q == StDone;
    // fifo_full is unreachable under the credit rule; gating on it is only a backstop.
    rd_req  = (state_q == StRun) && (rd_rem_q != '0) && credit_ok && !fifo_full;
    rd_addr = rd_addr_q;
    fifo_r_en = busy && !fifo_empty && (!hold_valid_q || wr_acc) && !pop_inflight_q;
    fifo_wdata = fifo_w_en ? rd_rdata : '0;
    wr_req  = hold_valid_q;
    wr_addr = wr_addr_q;
    wr_data = hold_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr_q      <= '0;
      wr_addr_q      <= '0;
      rd_rem_q       <= '0;
      wr_rem_q       <= '0;
      hold_valid_q   <= 1'b0;
      hold_data_q    <= '0;
      pop_inflight_q <= 1'b0;
    end else begin
      if (start_acc) begin
        rd_addr_q <= src_addr;
        wr_addr_q <= dst_addr;
        rd_rem_q  <= xfer_len;
        wr_rem_q  <= xfer_len;
      end else begin
        if (rd_acc) begin
          rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
          rd_rem_q  <= rd_rem_q - LEN_WIDTH'(1);
        end
        if (wr_acc) begin
          wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
          wr_rem_q  <= wr_rem_q - LEN_WIDTH'(1);
        end
      end

      // FIFO read data lands one cycle after the pop.
      pop_inflight_q <= fifo_r_en;
      if (pop_inflight_q) begin
        hold_valid_q <= 1'b1;
        hold_data_q  <= fifo_rdata;
      end else if (wr_acc) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  dma_credit_cnt #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_credit (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_acc    (rd_acc),
    .rd_rvalid (rd_rvalid),
    .fifo_pop  (fifo_r_en),
    .fifo_push (fifo_w_en),
    .credit_ok (credit_ok)
  );

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl with a behavioural sync FIFO and memory responder.
module tb_dma_xfer_ctrl;

  logic        clk, rst_n, start;
  logic [15:0] src_addr, dst_addr, xfer_len;
  logic        busy, done, rd_req, rd_gnt, rd_rvalid;
  logic [15:0] rd_addr, wr_addr;
  logic [7:0]  rd_rdata, fifo_wdata, fifo_rdata, wr_data;
  logic        fifo_w_en, fifo_full, fifo_r_en, fifo_empty, wr_req, wr_gnt;

  dma_xfer_ctrl #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .LEN_WIDTH (16),
    .FIFO_DEPTH(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .xfer_len   (xfer_len),
    .busy       (busy),
    .done       (done),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_gnt     (rd_gnt),
    .rd_rvalid  (rd_rvalid),
    .rd_rdata   (rd_rdata),
    .fifo_w_en  (fifo_w_en),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_r_en  (fifo_r_en),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_data(input logic [15:0] a);
    return a[7:0] + 8'h11;
  endfunction

  // Sync FIFO model: 8 storage slots, so full only at 8 entries.
  logic [7:0] f_mem [8];
  logic [2:0] f_wp, f_rp;
  logic [3:0] fifo_cnt;
  int         f_udf = 0;

  assign fifo_full  = (fifo_cnt == 4'd8);
  assign fifo_empty = (fifo_cnt == 4'd0);

  always @(posedge clk) begin
    if (!rst_n) begin
      f_wp       <= '0;
      f_rp       <= '0;
      fifo_cnt   <= '0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_w_en) begin
        f_mem[f_wp] <= fifo_wdata;
        f_wp        <= f_wp + 3'd1;
      end
      if (fifo_r_en) begin
        if (fifo_cnt == 4'd0) f_udf <= f_udf + 1;
        fifo_rdata <= f_mem[f_rp];
        f_rp       <= f_rp + 3'd1;
      end
      fifo_cnt <= fifo_cnt + 4'(fifo_w_en) - 4'(fifo_r_en);
    end
  end

  // Memory responder and observers, all acting at the falling edge.
  int          cyc = 0, rd_lat = 1, wr_block = 0, used;
  int          max_used, full_seen, done_cnt, rd_req_seen, wr_req_seen, busy_seen;
  int          grants_at_unblock;
  logic [15:0] pipe_addr [$];
  int          pipe_due [$];
  logic [15:0] rd_addr_log [$];
  logic [15:0] wr_addr_log [$];
  logic [7:0]  wr_data_log [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pipe_addr.delete();
      pipe_due.delete();
      rd_rvalid = 1'b0;
      rd_rdata  = 8'h00;
      wr_gnt    = 1'b0;
    end else begin
      used = int'(fifo_cnt) + pipe_due.size();
      if (used > max_used) max_used = used;
      if (fifo_full) full_seen++;
      if (pipe_due.size() != 0 && pipe_due[0] == cyc) begin
        rd_rvalid = 1'b1;
        rd_rdata  = mem_data(pipe_addr[0]);
        void'(pipe_due.pop_front());
        void'(pipe_addr.pop_front());
      end else begin
        rd_rvalid = 1'b0;
        rd_rdata  = 8'h00;
      end
      if (rd_req && rd_gnt) begin
        rd_addr_log.push_back(rd_addr);
        pipe_addr.push_back(rd_addr);
        pipe_due.push_back(cyc + rd_lat);
      end
      if (wr_block > 0) begin
        wr_block--;
        wr_gnt = 1'b0;
        if (wr_block == 0) grants_at_unblock = rd_addr_log.size();
      end else begin
        wr_gnt = 1'b1;
      end
      if (wr_req && wr_gnt) begin
        wr_addr_log.push_back(wr_addr);
        wr_data_log.push_back(wr_data);
      end
      if (done) done_cnt++;
      if (rd_req) rd_req_seen++;
      if (wr_req) wr_req_seen++;
      if (busy) busy_seen++;
    end
  end

  task automatic launch(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clk);
    rd_addr_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    done_cnt = 0; rd_req_seen = 0; wr_req_seen = 0; busy_seen = 0;
    max_used = 0; full_seen = 0;
    src_addr = s; dst_addr = d; xfer_len = l;
    start = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!done && lat < 1000);
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_xfer(input string pfx, input logic [15:0] s, input logic [15:0] d,
                            input int n);
    check({pfx, "_nrd"}, rd_addr_log.size(), n);
    check({pfx, "_nwr"}, wr_addr_log.size(), n);
    for (int i = 0; i < n && i < rd_addr_log.size(); i++)
      check($sformatf("%s_ra%0d", pfx, i), rd_addr_log[i], 16'(s + i));
    for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
      check($sformatf("%s_wa%0d", pfx, i), wr_addr_log[i], 16'(d + i));
      check($sformatf("%s_wd%0d", pfx, i), wr_data_log[i], mem_data(16'(s + i)));
    end
  endtask

  task automatic check_idle_zero(input string pfx);
    check({pfx, "_ctl"}, {busy, done, rd_req, fifo_w_en, fifo_r_en, wr_req}, 32'd0);
    check({pfx, "_rd_addr"}, rd_addr, 32'd0);
    check({pfx, "_wr_addr"}, wr_addr, 32'd0);
    check({pfx, "_wr_data"}, wr_data, 32'd0);
    check({pfx, "_fifo_wdata"}, fifo_wdata, 32'd0);
  endtask

  int lat, to;

  initial begin
    rst_n = 1'b0; start = 1'b0; rd_gnt = 1'b1;
    src_addr = '0; dst_addr = '0; xfer_len = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("rst");
    rst_n = 1'b1;

    // Basic 4-beat copy
    launch(16'h0100, 16'h0200, 16'd4);
    wait_done(lat);
    repeat (3) @(negedge clk);
    check_xfer("b4", 16'h0100, 16'h0200, 4);
    check("b4_wd0", wr_data_log[0], 32'h11);
    check("b4_wd3", wr_data_log[3], 32'h14);
    check("b4_done_cnt", done_cnt, 1);

    // Minimum latency, single beat
    launch(16'h0050, 16'h0060, 16'd1);
    wait_done(lat);
    check("len1_latency", lat, 6);
    repeat (2) @(negedge clk);
    check_xfer("len1", 16'h0050, 16'h0060, 1);

    // Zero-length start
    launch(16'h0700, 16'h0800, 16'd0);
    wait_done(lat);
    check("len0_latency", lat, 1);
    repeat (3) @(negedge clk);
    check("len0_rd_req", rd_req_seen, 0);
    check("len0_wr_req", wr_req_seen, 0);
    check("len0_busy", busy_seen, 0);
    check("len0_done_cnt", done_cnt, 1);

    // Back-pressure: slow reads, writes blocked for 30 cycles
    rd_lat = 5;
    wr_block = 30;
    launch(16'h0010, 16'h0500, 16'd20);
    wait_done(lat);
    repeat (3) @(negedge clk);
    check("stall_max_inflight", max_used, 7);
    check("stall_grants_blocked", grants_at_unblock, 8);
    check("stall_full_seen", full_seen, 0);
    check_xfer("stall", 16'h0010, 16'h0500, 20);
    check("stall_done_cnt", done_cnt, 1);
    rd_lat = 1;

    // Address wrap on both sides
    launch(16'hFFFE, 16'hFFFF, 16'd3);
    wait_done(lat);
    repeat (3) @(negedge clk);
    check_xfer("wrap", 16'hFFFE, 16'hFFFF, 3);
    check("wrap_ra2", rd_addr_log[2], 32'h0000);
    check("wrap_wa2", wr_addr_log[2], 32'h0001);
    check("wrap_wd0", wr_data_log[0], 32'h0F);

    // Start while busy must be ignored
    launch(16'h0300, 16'h0400, 16'd5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_hi", busy, 1);
    src_addr = 16'h0500; dst_addr = 16'h0600; xfer_len = 16'd2;
    start = 1'b1;
    wait_done(lat);
    repeat (6) @(negedge clk);
    check_xfer("busy_start", 16'h0300, 16'h0400, 5);
    check("busy_start_done_cnt", done_cnt, 1);
    check("busy_start_idle", busy, 0);

    // Reset mid-transfer at beat 3 of 10
    launch(16'h1000, 16'h2000, 16'd10);
    to = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      to++;
    end while (wr_addr_log.size() < 3 && to < 200);
    check("rst_mid_reached", wr_addr_log.size() >= 3, 1);
    rst_n = 1'b0;
    done_cnt = 0;
    @(negedge clk);
    check_idle_zero("rst_mid");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_idle", busy, 0);
    launch(16'h0040, 16'h0080, 16'd2);
    wait_done(lat);
    repeat (3) @(negedge clk);
    check_xfer("post_rst", 16'h0040, 16'h0080, 2);
    check("post_rst_done_cnt", done_cnt, 1);

    check("fifo_underflow", f_udf, 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
